// File: rtl/wb_req_arbiter.sv
// wb_req_arbiter: N-way arbiter for cache writeback/release requests feeding one writeback unit.
//
// Each channel presents a request (tag, idx, param, way_en, voluntary) plus a `last` flag that
// marks the final beat of a multi-beat transaction. A combinational one-hot grant picks a channel
// (round-robin or fixed priority), and the accepted beat is captured in a single registered
// output slot. Once a channel sends a beat with last=0 it owns the arbiter until it sends last=1.
//
// Parameters:
//   N        number of request channels (>= 2)
//   TAG_W    tag width
//   IDX_W    set index width
//   PARAM_W  TileLink shrink/report param width
//   WAY_W    one-hot way enable width
//   RR       1 = round-robin, 0 = fixed priority (channel 0 highest)
//
// Ports:
//   clock                 sole clock, rising edge
//   reset                 synchronous, active-low
//   io_in_valid[N]        per-channel request valid
//   io_in_ready[N]        per-channel accept (only ever set for the granted channel)
//   io_in_bits_*          packed per-channel payload, channel i at [i*W +: W]
//   io_in_bits_last[N]    1 = final beat of the channel's transaction
//   io_out_ready          downstream accept
//   io_out_valid          registered output valid
//   io_out_bits_*         registered payload of the accepted beat
//   io_out_chosen         registered index of the channel that supplied the payload
//
// Optional build macro:
//   WB_ARB_ASSERT_EN      compiles in simulation-only protocol/fairness assertions.
//                         Without it no assertion code exists and the logic is unchanged.

module wb_req_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TAG_W   = 20,
  parameter int unsigned IDX_W   = 6,
  parameter int unsigned PARAM_W = 3,
  parameter int unsigned WAY_W   = 8,
  parameter int unsigned RR      = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N-1:0]           io_in_valid,
  output logic [N-1:0]           io_in_ready,
  input  logic [N*TAG_W-1:0]     io_in_bits_tag,
  input  logic [N*IDX_W-1:0]     io_in_bits_idx,
  input  logic [N*PARAM_W-1:0]   io_in_bits_param,
  input  logic [N*WAY_W-1:0]     io_in_bits_way_en,
  input  logic [N-1:0]           io_in_bits_voluntary,
  input  logic [N-1:0]           io_in_bits_last,
  input  logic                   io_out_ready,
  output logic                   io_out_valid,
  output logic [TAG_W-1:0]       io_out_bits_tag,
  output logic [IDX_W-1:0]       io_out_bits_idx,
  output logic [PARAM_W-1:0]     io_out_bits_param,
  output logic [WAY_W-1:0]       io_out_bits_way_en,
  output logic                   io_out_bits_voluntary,
  output logic [$clog2(N)-1:0]   io_out_chosen
);

  localparam int unsigned CW = $clog2(N);

  // Output slot
  logic               out_valid_q, out_valid_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PARAM_W-1:0] param_q, param_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic               vol_q, vol_d;
  logic [CW-1:0]      chosen_q, chosen_d;

  // Arbitration state
  logic               lock_q, lock_d;
  logic [CW-1:0]      lock_id_q, lock_id_d;
  logic [CW-1:0]      ptr_q, ptr_d;

  // Combinational arbitration
  logic [N-1:0]       hi_mask;
  logic [N-1:0]       pick_vec;
  logic [N-1:0]       grant_free;
  logic [N-1:0]       grant_lock;
  logic [N-1:0]       grant;
  logic               found;
  logic               enq;
  logic [N-1:0]       fire;
  logic               fire_any;

  // Selected (granted) channel payload
  logic [CW-1:0]      win_idx;
  logic               win_last;
  logic [TAG_W-1:0]   sel_tag;
  logic [IDX_W-1:0]   sel_idx;
  logic [PARAM_W-1:0] sel_param;
  logic [WAY_W-1:0]   sel_way;
  logic               sel_vol;
  logic [CW-1:0]      ptr_next;

  // Round-robin: prefer valid channels at or above ptr; if none, wrap to the lowest valid one.
  // Fixed priority is the same search with the upper-half preference disabled.
  always_comb begin
    hi_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hi_mask[i] = io_in_valid[i] & (CW'(i) >= ptr_q);
    end
    pick_vec = ((RR != 0) && (hi_mask != '0)) ? hi_mask : io_in_valid;

    grant_free = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && pick_vec[i]) begin
        grant_free[i] = 1'b1;
        found         = 1'b1;
      end
    end

    // While locked only the owner may be granted; if it idles, nobody is.
    grant_lock            = '0;
    grant_lock[lock_id_q] = io_in_valid[lock_id_q];

    grant = lock_q ? grant_lock : grant_free;
  end

  // The slot can take a beat when empty or when its current beat leaves this cycle.
  assign enq         = ~out_valid_q | io_out_ready;
  assign io_in_ready = grant & {N{enq}};
  assign fire        = io_in_valid & io_in_ready;
  assign fire_any    = |fire;

  always_comb begin
    win_idx   = '0;
    win_last  = 1'b0;
    sel_tag   = '0;
    sel_idx   = '0;
    sel_param = '0;
    sel_way   = '0;
    sel_vol   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) begin
        win_idx   = CW'(i);
        win_last  = io_in_bits_last[i];
        sel_tag   = io_in_bits_tag[i*TAG_W +: TAG_W];
        sel_idx   = io_in_bits_idx[i*IDX_W +: IDX_W];
        sel_param = io_in_bits_param[i*PARAM_W +: PARAM_W];
        sel_way   = io_in_bits_way_en[i*WAY_W +: WAY_W];
        sel_vol   = io_in_bits_voluntary[i];
      end
    end
  end

  // Explicit wrap keeps non-power-of-two N correct.
  assign ptr_next = (win_idx == CW'(N - 1)) ? '0 : win_idx + CW'(1);

  always_comb begin
    out_valid_d = out_valid_q;
    tag_d       = tag_q;
    idx_d       = idx_q;
    param_d     = param_q;
    way_d       = way_q;
    vol_d       = vol_q;
    chosen_d    = chosen_q;
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
    ptr_d       = ptr_q;

    if (enq) begin
      out_valid_d = fire_any;
      if (fire_any) begin
        tag_d    = sel_tag;
        idx_d    = sel_idx;
        param_d  = sel_param;
        way_d    = sel_way;
        vol_d    = sel_vol;
        chosen_d = win_idx;
      end
    end

    if (fire_any) begin
      if (win_last) begin
        // Transaction complete: release ownership and rotate priority past the winner.
        lock_d = 1'b0;
        ptr_d  = ptr_next;
      end else begin
        lock_d    = 1'b1;
        lock_id_d = win_idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      tag_q       <= '0;
      idx_q       <= '0;
      param_q     <= '0;
      way_q       <= '0;
      vol_q       <= 1'b0;
      chosen_q    <= '0;
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      tag_q       <= tag_d;
      idx_q       <= idx_d;
      param_q     <= param_d;
      way_q       <= way_d;
      vol_q       <= vol_d;
      chosen_q    <= chosen_d;
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign io_out_valid          = out_valid_q;
  assign io_out_bits_tag       = tag_q;
  assign io_out_bits_idx       = idx_q;
  assign io_out_bits_param     = param_q;
  assign io_out_bits_way_en    = way_q;
  assign io_out_bits_voluntary = vol_q;
  assign io_out_chosen         = chosen_q;

`ifdef WB_ARB_ASSERT_EN
  // A locked owner mid-transaction that is being back-pressured must keep its request up.
  a_lock_hold: assert property (@(posedge clock) disable iff (!reset)
    lock_q && io_in_valid[lock_id_q] && !io_in_bits_last[lock_id_q] && !io_in_ready[lock_id_q]
    |=> io_in_valid[lock_id_q]);

  a_out_stable: assert property (@(posedge clock) disable iff (!reset)
    io_out_valid && !io_out_ready
    |=> io_out_valid && $stable({io_out_bits_tag, io_out_bits_idx, io_out_bits_param,
                                 io_out_bits_way_en, io_out_bits_voluntary, io_out_chosen}));

  a_grant_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot0(grant));

  // Count completed transactions by other channels while a channel waits continuously.
  int unsigned wait_cnt [N];

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (!reset || !io_in_valid[i] || fire[i]) begin
        wait_cnt[i] <= 0;
      end else if (fire_any && win_last) begin
        wait_cnt[i] <= wait_cnt[i] + 1;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_starve
    a_no_starve: assert property (@(posedge clock) disable iff (!reset)
      (RR == 0) || (wait_cnt[g] <= N));
  end
`endif

endmodule

// File: tb/tb_wb_req_arbiter.sv
// Self-checking bench for wb_req_arbiter (N=4). A round-robin instance is checked through a
// scoreboard of expected output beats plus inline ready/valid checks; a fixed-priority
// instance sharing the same inputs is checked inline where its behaviour differs.

module tb_wb_req_arbiter;

  localparam int unsigned N       = 4;
  localparam int unsigned TAG_W   = 20;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned PARAM_W = 3;
  localparam int unsigned WAY_W   = 8;

  typedef struct packed {
    logic [1:0]  ch;
    logic [19:0] tag;
    logic [5:0]  idx;
    logic [2:0]  param;
    logic [7:0]  way;
    logic        vol;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [3:0]   valid;
  logic [3:0]   last;
  logic [19:0]  tag_a [4];
  logic         out_ready;

  logic [N*TAG_W-1:0]   tag_bus;
  logic [N*IDX_W-1:0]   idx_bus;
  logic [N*PARAM_W-1:0] param_bus;
  logic [N*WAY_W-1:0]   way_bus;
  logic [N-1:0]         vol_bus;

  logic [3:0]  in_ready, f_ready;
  logic        o_valid, f_valid;
  logic [19:0] o_tag, f_tag;
  logic [5:0]  o_idx, f_idx;
  logic [2:0]  o_param, f_param;
  logic [7:0]  o_way, f_way;
  logic        o_vol, f_vol;
  logic [1:0]  o_chosen, f_chosen;

  exp_t exp_q [$];
  int   total = 0;
  int   bad   = 0;

  // Per-channel payload is derived from its tag so each beat is distinguishable.
  function automatic exp_t mk(int ch, logic [19:0] t);
    exp_t e;
    e.ch    = 2'(ch);
    e.tag   = t;
    e.idx   = t[11:6];
    e.param = 3'(ch + 1);
    e.way   = 8'(1 << ch);
    e.vol   = t[0];
    return e;
  endfunction

  always_comb begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e = mk(i, tag_a[i]);
      tag_bus[i*TAG_W +: TAG_W]       = e.tag;
      idx_bus[i*IDX_W +: IDX_W]       = e.idx;
      param_bus[i*PARAM_W +: PARAM_W] = e.param;
      way_bus[i*WAY_W +: WAY_W]       = e.way;
      vol_bus[i]                      = e.vol;
    end
  end

  wb_req_arbiter #(.N(N), .TAG_W(TAG_W), .IDX_W(IDX_W), .PARAM_W(PARAM_W), .WAY_W(WAY_W),
                   .RR(1)) dut (
    .clock(clk), .reset(rst_n), .io_in_valid(valid), .io_in_ready(in_ready),
    .io_in_bits_tag(tag_bus), .io_in_bits_idx(idx_bus), .io_in_bits_param(param_bus),
    .io_in_bits_way_en(way_bus), .io_in_bits_voluntary(vol_bus), .io_in_bits_last(last),
    .io_out_ready(out_ready), .io_out_valid(o_valid), .io_out_bits_tag(o_tag),
    .io_out_bits_idx(o_idx), .io_out_bits_param(o_param), .io_out_bits_way_en(o_way),
    .io_out_bits_voluntary(o_vol), .io_out_chosen(o_chosen)
  );

  wb_req_arbiter #(.N(N), .TAG_W(TAG_W), .IDX_W(IDX_W), .PARAM_W(PARAM_W), .WAY_W(WAY_W),
                   .RR(0)) dut_fp (
    .clock(clk), .reset(rst_n), .io_in_valid(valid), .io_in_ready(f_ready),
    .io_in_bits_tag(tag_bus), .io_in_bits_idx(idx_bus), .io_in_bits_param(param_bus),
    .io_in_bits_way_en(way_bus), .io_in_bits_voluntary(vol_bus), .io_in_bits_last(last),
    .io_out_ready(out_ready), .io_out_valid(f_valid), .io_out_bits_tag(f_tag),
    .io_out_bits_idx(f_idx), .io_out_bits_param(f_param), .io_out_bits_way_en(f_way),
    .io_out_bits_voluntary(f_vol), .io_out_chosen(f_chosen)
  );

  // Scoreboard: every beat leaving the round-robin instance must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (o_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: got chosen=%0d tag=%h, required no beat", o_chosen, o_tag);
      end else begin
        e = exp_q.pop_front();
        if ({o_chosen, o_tag, o_idx, o_param, o_way, o_vol} !== e) begin
          bad++;
          $display("FAIL sb_beat: got chosen=%0d tag=%h idx=%h param=%h way=%h vol=%b, required chosen=%0d tag=%h idx=%h param=%h way=%h vol=%b",
                   o_chosen, o_tag, o_idx, o_param, o_way, o_vol,
                   e.ch, e.tag, e.idx, e.param, e.way, e.vol);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({o_valid, o_chosen, o_tag, o_idx, o_param, o_way, o_vol} !== '0) begin
      bad++;
      $display("FAIL reset_out: got valid=%b chosen=%0d tag=%h, required all zero",
               o_valid, o_chosen, o_tag);
    end
    total++;
    if ({f_valid, f_chosen, f_tag} !== '0) begin
      bad++;
      $display("FAIL reset_fp_out: got valid=%b chosen=%0d tag=%h, required all zero",
               f_valid, f_chosen, f_tag);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_fixed_priority();
    tag_a[1] = 20'h11;
    tag_a[2] = 20'h22;
    last     = 4'b1111;
    valid    = 4'b0110;
    @(negedge clk);
    total++;
    if (f_ready !== 4'b0010) begin
      bad++; $display("FAIL fp_ready0: got %b required 0010", f_ready);
    end
    total++;
    if (in_ready !== 4'b0010) begin
      bad++; $display("FAIL rr_ready0: got %b required 0010", in_ready);
    end
    exp_q.push_back(mk(1, tag_a[1]));
    tick();
    @(negedge clk);
    total++;
    if ({f_valid, f_tag, f_chosen} !== {1'b1, 20'h11, 2'd1}) begin
      bad++;
      $display("FAIL fp_out1: got valid=%b tag=%h chosen=%0d, required valid=1 tag=00011 chosen=1",
               f_valid, f_tag, f_chosen);
    end
    // Fixed priority keeps favouring ch1; round-robin has rotated to ch2.
    total++;
    if (f_ready !== 4'b0010) begin
      bad++; $display("FAIL fp_ready1: got %b required 0010", f_ready);
    end
    total++;
    if (in_ready !== 4'b0100) begin
      bad++; $display("FAIL rr_ready1: got %b required 0100", in_ready);
    end
    exp_q.push_back(mk(2, tag_a[2]));
    tick();
    valid = 4'b0000;
    @(negedge clk);
    total++;
    if ({f_valid, f_chosen} !== {1'b1, 2'd1}) begin
      bad++; $display("FAIL fp_out2: got valid=%b chosen=%0d, required valid=1 chosen=1",
                      f_valid, f_chosen);
    end
    tick();
    @(negedge clk);
    total++;
    if (o_valid !== 1'b0) begin
      bad++; $display("FAIL rr_drain: got valid=%b required 0", o_valid);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    do_reset();
    for (int i = 0; i < 4; i++) tag_a[i] = 20'h01000 + 20'(i * 65);
    last  = 4'b1111;
    valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp_rdy = 4'(1 << (k % 4));
      total++;
      if (in_ready !== exp_rdy) begin
        bad++; $display("FAIL rr_seq_ready%0d: got %b required %b", k, in_ready, exp_rdy);
      end
      if (k > 0) begin
        total++;
        if (o_valid !== 1'b1) begin
          bad++; $display("FAIL rr_seq_bubble%0d: got valid=%b required 1", k, o_valid);
        end
      end
      exp_q.push_back(mk(k % 4, tag_a[k % 4]));
      tick();
    end
    valid = 4'b0000;
    @(negedge clk);
    tick();
  endtask

  task automatic test_lock();
    // ptr now points at ch1, so ch2 wins over ch0 and then holds the arbiter.
    tag_a[0] = 20'h00200;
    last     = 4'b1111;
    valid    = 4'b0101;
    for (int b = 0; b < 3; b++) begin
      tag_a[2] = 20'h00201 + 20'(b);
      last[2]  = (b == 2);
      @(negedge clk);
      total++;
      if (in_ready !== 4'b0100) begin
        bad++; $display("FAIL lock_ready%0d: got %b required 0100", b, in_ready);
      end
      exp_q.push_back(mk(2, tag_a[2]));
      tick();
    end
    valid = 4'b0001;
    @(negedge clk);
    total++;
    if (in_ready !== 4'b0001) begin
      bad++; $display("FAIL lock_release: got %b required 0001", in_ready);
    end
    exp_q.push_back(mk(0, tag_a[0]));
    tick();
    valid = 4'b0000;
    @(negedge clk);
    tick();
  endtask

  task automatic test_stall();
    tag_a[1]  = 20'hABCDE;
    last      = 4'b1111;
    valid     = 4'b0010;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 4'b0010) begin
      bad++; $display("FAIL stall_first: got %b required 0010", in_ready);
    end
    exp_q.push_back(mk(1, tag_a[1]));
    tick();
    tag_a[1]  = 20'h12345;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({o_valid, o_tag, o_chosen, in_ready} !== {1'b1, 20'hABCDE, 2'd1, 4'b0000}) begin
        bad++;
        $display("FAIL stall_hold%0d: got valid=%b tag=%h chosen=%0d ready=%b, required 1 abcde 1 0000",
                 c, o_valid, o_tag, o_chosen, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 4'b0010) begin
      bad++; $display("FAIL stall_resume: got %b required 0010", in_ready);
    end
    exp_q.push_back(mk(1, tag_a[1]));
    tick();
    valid = 4'b0000;
    @(negedge clk);
    total++;
    if ({o_valid, o_tag} !== {1'b1, 20'h12345}) begin
      bad++; $display("FAIL stall_nogap: got valid=%b tag=%h, required valid=1 tag=12345",
                      o_valid, o_tag);
    end
    tick();
  endtask

  task automatic test_lock_idle();
    tag_a[1] = 20'h00501;
    tag_a[3] = 20'h00503;
    last     = 4'b1101;
    valid    = 4'b0010;
    @(negedge clk);
    total++;
    if (in_ready !== 4'b0010) begin
      bad++; $display("FAIL idle_start: got %b required 0010", in_ready);
    end
    exp_q.push_back(mk(1, tag_a[1]));
    tick();
    valid = 4'b1000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 4'b0000) begin
        bad++; $display("FAIL idle_nogrant%0d: got %b required 0000", c, in_ready);
      end
      total++;
      if (o_valid !== (c == 0)) begin
        bad++; $display("FAIL idle_valid%0d: got %b required %b", c, o_valid, c == 0);
      end
      tick();
    end
    tag_a[1] = 20'h00502;
    last     = 4'b1111;
    valid    = 4'b1010;
    @(negedge clk);
    total++;
    if (in_ready !== 4'b0010) begin
      bad++; $display("FAIL idle_resume: got %b required 0010", in_ready);
    end
    exp_q.push_back(mk(1, tag_a[1]));
    tick();
    valid = 4'b1000;
    @(negedge clk);
    total++;
    if (in_ready !== 4'b1000) begin
      bad++; $display("FAIL idle_next: got %b required 1000", in_ready);
    end
    exp_q.push_back(mk(3, tag_a[3]));
    tick();
    valid = 4'b0000;
    @(negedge clk);
    tick();
  endtask

  task automatic test_reset_mid_lock();
    tag_a[0] = 20'h00601;
    last     = 4'b1110;
    valid    = 4'b0001;
    @(negedge clk);
    total++;
    if (in_ready !== 4'b0001) begin
      bad++; $display("FAIL rst_lock_start: got %b required 0001", in_ready);
    end
    exp_q.push_back(mk(0, tag_a[0]));
    tick();
    rst_n    = 1'b0;
    tag_a[0] = 20'h00602;
    @(negedge clk);
    tick();
    rst_n    = 1'b1;
    tag_a[3] = 20'h00603;
    last     = 4'b1111;
    valid    = 4'b1000;
    @(negedge clk);
    total++;
    if ({o_valid, o_chosen, o_tag} !== {1'b0, 2'd0, 20'h0}) begin
      bad++; $display("FAIL rst_lock_out: got valid=%b chosen=%0d tag=%h, required all zero",
                      o_valid, o_chosen, o_tag);
    end
    total++;
    if (in_ready !== 4'b1000) begin
      bad++; $display("FAIL rst_lock_clear: got %b required 1000", in_ready);
    end
    exp_q.push_back(mk(3, tag_a[3]));
    tick();
    valid = 4'b0000;
    @(negedge clk);
    total++;
    if ({o_valid, o_chosen} !== {1'b1, 2'd3}) begin
      bad++; $display("FAIL rst_lock_after: got valid=%b chosen=%0d, required valid=1 chosen=3",
                      o_valid, o_chosen);
    end
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    valid     = 4'b0000;
    last      = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tag_a[i] = '0;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_lock();
    test_stall();
    test_lock_idle();
    test_reset_mid_lock();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d pending beats, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
